// File: rtl/uart_mmio_if.sv
// -----------------------------------------------------------------------------
// uart_mmio_if
// CPU data-bus slice seen by the UART peripheral: chip select, read/write
// strobes (all active low), byte address, write data and read data.
//   master : CPU side / address decoder (drives strobes, address, write data)
//   slave  : peripheral side (drives DataOut)
// -----------------------------------------------------------------------------
interface uart_mmio_if;
  logic        CS_N;
  logic        RD_N;
  logic        WR_N;
  logic [11:0] Addr;
  logic [31:0] DataIn;
  logic [31:0] DataOut;

  modport master (
    output CS_N, RD_N, WR_N, Addr, DataIn,
    input  DataOut
  );

  modport slave (
    input  CS_N, RD_N, WR_N, Addr, DataIn,
    output DataOut
  );
endinterface

// File: rtl/uart_mmio.sv
// -----------------------------------------------------------------------------
// uart_mmio
// Memory-mapped 8N1 UART: one transmitter, one receiver, programmable bit
// period, sticky status flags and a registered level interrupt.
//
// Ports
//   clk       system clock
//   reset     asynchronous, active-high reset
//   bus       CPU bus slice (slave modport); DataOut is combinational, 0 when
//             the block is not selected
//   Intr      level interrupt, registered
//   UART_TXD  serial transmit, idles high
//   UART_RXD  serial receive, asynchronous to clk
//
// Register map (Addr[3:2])
//   0 DATA     wr [7:0] = TX byte (ignored while tx_busy) / rd {24'b0, rx_byte}
//   1 STATUS   rd {ferr, ovr, tx_busy, rx_valid}; read clears ovr and ferr
//   2 CTRL     [0] rx_ie, [1] tx_ie
//   3 BAUDDIV  [DIV_W-1:0] clocks per bit, writes below 4 stored as 4
//
// TX FSM
//   state    | meaning
//   TX_IDLE  | line high, waiting for a DATA write
//   TX_START | driving start bit (0) for tx_div clocks
//   TX_DATA  | driving 8 data bits, LSB first, tx_div clocks each
//   TX_STOP  | driving stop bit (1); tx_busy drops when it ends
//
// RX FSM
//   state    | meaning
//   RX_IDLE  | waiting for a falling edge on the synchronized line
//   RX_START | counting to the start-bit midpoint; high there = glitch
//   RX_DATA  | sampling 8 data bits one bit period apart, LSB first
//   RX_STOP  | sampling the stop bit; completion delivers the byte
// -----------------------------------------------------------------------------
module uart_mmio #(
  parameter int DEFAULT_DIV = 434,
  parameter int DIV_W       = 16
) (
  input  logic        clk,
  input  logic        reset,
  uart_mmio_if.slave  bus,
  output logic        Intr,
  output logic        UART_TXD,
  input  logic        UART_RXD
);

  localparam logic [1:0]       A_DATA   = 2'd0;
  localparam logic [1:0]       A_STATUS = 2'd1;
  localparam logic [1:0]       A_CTRL   = 2'd2;
  localparam logic [1:0]       A_BAUD   = 2'd3;
  localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);
  localparam logic [DIV_W-1:0] DIV_MIN  = DIV_W'(4);

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

  // ---------------------------------------------------------------------------
  // Bus decode
  // ---------------------------------------------------------------------------
  logic             w_sel, w_wr, w_rd;
  logic [1:0]       w_reg;
  logic             w_wr_data, w_wr_ctrl, w_wr_baud;
  logic             w_rd_data, w_rd_stat;
  logic [DIV_W-1:0] w_div_in, w_div_clamped;
  logic             w_unused;

  assign w_sel     = ~bus.CS_N;
  assign w_wr      = w_sel & ~bus.WR_N;
  // A read needs WR_N high so a simultaneous write strobe never triggers
  // read side effects.
  assign w_rd      = w_sel & ~bus.RD_N & bus.WR_N;
  assign w_reg     = bus.Addr[3:2];
  assign w_wr_data = w_wr && (w_reg == A_DATA);
  assign w_wr_ctrl = w_wr && (w_reg == A_CTRL);
  assign w_wr_baud = w_wr && (w_reg == A_BAUD);
  assign w_rd_data = w_rd && (w_reg == A_DATA);
  assign w_rd_stat = w_rd && (w_reg == A_STATUS);

  assign w_div_in      = bus.DataIn[DIV_W-1:0];
  assign w_div_clamped = (w_div_in < DIV_MIN) ? DIV_MIN : w_div_in;

  assign w_unused = &{1'b0, bus.Addr[11:4], bus.Addr[1:0], bus.DataIn[31:DIV_W]};

  // ---------------------------------------------------------------------------
  // Registers and flags
  // ---------------------------------------------------------------------------
  logic [1:0]       r_ctrl;
  logic [DIV_W-1:0] r_div;
  logic [7:0]       r_rx_byte;
  logic             r_rx_valid, r_ovr, r_ferr, r_intr;

  // TX state
  tx_state_t        r_tx_state;
  logic [DIV_W-1:0] r_tx_div, r_tx_cnt;
  logic [7:0]       r_tx_shift;
  logic [2:0]       r_tx_bit;
  logic             r_tx_busy, r_txd;

  // RX state
  rx_state_t        r_rx_state;
  logic [DIV_W-1:0] r_rx_div, r_rx_cnt;
  logic [7:0]       r_rx_shift;
  logic [2:0]       r_rx_bit;
  logic             r_rxd_s1, r_rxd_s2, r_rxd_s3;

  // Completion is decoded combinationally so delivery, the overrun decision
  // and a concurrent DATA read all resolve on the same edge.
  logic w_rx_done;
  assign w_rx_done = (r_rx_state == RX_STOP) && (r_rx_cnt == '0);

  // ---------------------------------------------------------------------------
  // Read data mux
  // ---------------------------------------------------------------------------
  always_comb begin
    bus.DataOut = 32'd0;
    if (w_sel) begin
      unique case (w_reg)
        A_DATA:   bus.DataOut = {24'd0, r_rx_byte};
        A_STATUS: bus.DataOut = {28'd0, r_ferr, r_ovr, r_tx_busy, r_rx_valid};
        A_CTRL:   bus.DataOut = {30'd0, r_ctrl};
        A_BAUD:   bus.DataOut = {{(32-DIV_W){1'b0}}, r_div};
        default:  bus.DataOut = 32'd0;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Config registers, RX delivery, flags, interrupt
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ctrl     <= 2'd0;
      r_div      <= DIV_W'(DEFAULT_DIV);
      r_rx_byte  <= 8'd0;
      r_rx_valid <= 1'b0;
      r_ovr      <= 1'b0;
      r_ferr     <= 1'b0;
      r_intr     <= 1'b0;
    end else begin
      if (w_wr_ctrl) r_ctrl <= bus.DataIn[1:0];
      if (w_wr_baud) r_div  <= w_div_clamped;

      // Clear first so a flag raised on the same edge survives the read.
      if (w_rd_stat) begin
        r_ovr  <= 1'b0;
        r_ferr <= 1'b0;
      end

      if (w_rx_done) begin
        // A DATA read on the completion edge frees the holding register,
        // so the new byte replaces the old one without an overrun.
        if (!r_rx_valid || w_rd_data) begin
          r_rx_byte  <= r_rx_shift;
          r_rx_valid <= 1'b1;
        end else begin
          r_ovr <= 1'b1;
        end
        if (!r_rxd_s2) r_ferr <= 1'b1;
      end else if (w_rd_data) begin
        r_rx_valid <= 1'b0;
      end

      r_intr <= (r_rx_valid & r_ctrl[0]) | (~r_tx_busy & r_ctrl[1]);
    end
  end

  // ---------------------------------------------------------------------------
  // TX FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_tx_state <= TX_IDLE;
      r_tx_div   <= '0;
      r_tx_cnt   <= '0;
      r_tx_shift <= 8'd0;
      r_tx_bit   <= 3'd0;
      r_tx_busy  <= 1'b0;
      r_txd      <= 1'b1;
    end else begin
      unique case (r_tx_state)
        TX_IDLE: begin
          if (w_wr_data) begin
            r_tx_shift <= bus.DataIn[7:0];
            r_tx_div   <= r_div;
            r_tx_cnt   <= r_div - DIV_ONE;
            r_tx_busy  <= 1'b1;
            r_txd      <= 1'b0;
            r_tx_state <= TX_START;
          end
        end
        TX_START: begin
          if (r_tx_cnt == '0) begin
            r_txd      <= r_tx_shift[0];
            r_tx_cnt   <= r_tx_div - DIV_ONE;
            r_tx_bit   <= 3'd0;
            r_tx_state <= TX_DATA;
          end else begin
            r_tx_cnt <= r_tx_cnt - DIV_ONE;
          end
        end
        TX_DATA: begin
          if (r_tx_cnt == '0) begin
            r_tx_cnt <= r_tx_div - DIV_ONE;
            if (r_tx_bit == 3'd7) begin
              r_txd      <= 1'b1;
              r_tx_state <= TX_STOP;
            end else begin
              r_tx_shift <= {1'b0, r_tx_shift[7:1]};
              r_txd      <= r_tx_shift[1];
              r_tx_bit   <= r_tx_bit + 3'd1;
            end
          end else begin
            r_tx_cnt <= r_tx_cnt - DIV_ONE;
          end
        end
        TX_STOP: begin
          if (r_tx_cnt == '0) begin
            r_tx_busy  <= 1'b0;
            r_tx_state <= TX_IDLE;
          end else begin
            r_tx_cnt <= r_tx_cnt - DIV_ONE;
          end
        end
        default: r_tx_state <= TX_IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // RX synchronizer and FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rxd_s1   <= 1'b1;
      r_rxd_s2   <= 1'b1;
      r_rxd_s3   <= 1'b1;
      r_rx_state <= RX_IDLE;
      r_rx_div   <= '0;
      r_rx_cnt   <= '0;
      r_rx_shift <= 8'd0;
      r_rx_bit   <= 3'd0;
    end else begin
      r_rxd_s1 <= UART_RXD;
      r_rxd_s2 <= r_rxd_s1;
      // s3 is only the previous synchronized value, for edge detection.
      r_rxd_s3 <= r_rxd_s2;

      unique case (r_rx_state)
        RX_IDLE: begin
          // Falling edge only: a line stuck low after a bad stop bit must
          // return high before another frame is accepted.
          if (r_rxd_s3 && !r_rxd_s2) begin
            r_rx_div   <= r_div;
            r_rx_cnt   <= (r_div >> 1) - DIV_ONE;
            r_rx_state <= RX_START;
          end
        end
        RX_START: begin
          if (r_rx_cnt == '0) begin
            if (r_rxd_s2) begin
              r_rx_state <= RX_IDLE;
            end else begin
              r_rx_cnt   <= r_rx_div - DIV_ONE;
              r_rx_bit   <= 3'd0;
              r_rx_state <= RX_DATA;
            end
          end else begin
            r_rx_cnt <= r_rx_cnt - DIV_ONE;
          end
        end
        RX_DATA: begin
          if (r_rx_cnt == '0) begin
            r_rx_shift <= {r_rxd_s2, r_rx_shift[7:1]};
            r_rx_cnt   <= r_rx_div - DIV_ONE;
            if (r_rx_bit == 3'd7) r_rx_state <= RX_STOP;
            else                  r_rx_bit   <= r_rx_bit + 3'd1;
          end else begin
            r_rx_cnt <= r_rx_cnt - DIV_ONE;
          end
        end
        RX_STOP: begin
          if (r_rx_cnt == '0) r_rx_state <= RX_IDLE;
          else                r_rx_cnt   <= r_rx_cnt - DIV_ONE;
        end
        default: r_rx_state <= RX_IDLE;
      endcase
    end
  end

  assign Intr     = r_intr;
  assign UART_TXD = r_txd;

endmodule
